pp_mult_seq_ctrl: RTL
=====================

// Module: pp_mult_seq_ctrl
// PURPOSE
//  Sequential controller that computes an unsigned WIDTH x WIDTH product one partial-product row per cycle.
//  Each cycle it selects multiplier bit y[i], gates x with it (one AND row), shifts the row by i and adds it into a 2*WIDTH accumulator.
//  It sits between an upstream operand source and a downstream consumer, both using valid/ready handshakes.
//  It is the low-area serial alternative to the parallel Dadda-tree multiplier, built on the same partial-product definition.
// PARAMETERS
//  WIDTH   4   operand width in bits (>=2); product is 2*WIDTH bits
//  CNT_W   2   row-counter width, must equal clog2(WIDTH)
// PORTS
//  clk        in   1         rising-edge clock
//  rst        in   1         asynchronous, active-high reset
//  in_valid   in   1         operands x/y valid
//  in_ready   out  1         controller can accept operands (IDLE only)
//  x          in   WIDTH     multiplicand
//  y          in   WIDTH     multiplier
//  out_valid  out  1         product p valid
//  out_ready  in   1         consumer accepts p
//  p          out  2*WIDTH   product
//  busy       out  1         high in ACCUM or DONE
//  row_idx    out  CNT_W     current row being accumulated (debug; 0 outside ACCUM)
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, acc=0, cnt=0, x_r=0, y_r=0; in_ready=1, out_valid=0, busy=0, p=0, row_idx=0.
//  FSM states:
//   IDLE:  in_ready=1. If in_valid at clk edge: latch x_r=x, y_r=y, acc=0, cnt=0, go to ACCUM.
//   ACCUM: in_ready=0. Each edge: acc += ({WIDTH{y_r[cnt]}} & x_r) << cnt, cnt++.
//          On the edge where cnt==WIDTH-1, add the last row and go to DONE (cnt wraps to 0).
//   DONE:  out_valid=1, p=acc held stable. If out_ready at an edge, go to IDLE. Otherwise stay in DONE.
//  Latency: the accept edge is edge 0. out_valid rises after edge WIDTH, and is first visible in cycle WIDTH.
//   Throughput is one product per WIDTH+2 cycles when out_ready=1.
//  Width rules: acc is exactly 2*WIDTH bits. Max value (2^W-1)^2 < 2^(2W), so overflow is impossible and no carry-out is needed.
//   Each row is zero-extended to 2*WIDTH before the shift.
//  p mirrors acc only in DONE. p is 0 in IDLE and ACCUM, so no partial sums leak to the consumer.
//  Boundary conditions:
//   - in_valid while busy: ignored (in_ready=0). x/y changes during ACCUM/DONE have no effect (latched copies are used).
//   - DONE->IDLE: there is no same-cycle accept. in_ready is 1 in the cycle after the handshake.
//   - out_ready held low: DONE persists indefinitely and p stays constant.
//   - y==0 or x==0: the full WIDTH cycles still elapse (fixed latency), then p=0.
//   - rst mid-ACCUM or mid-DONE: the operation is aborted and no out_valid is produced. The FSM returns to IDLE.
//   - Illegal state encoding: next state is IDLE.
// STRUCTURE
//  Shared package/include (pp_mult_pkg): state encodings ST_IDLE=2'd0, ST_ACCUM=2'd1, ST_DONE=2'd2, plus the default WIDTH.
//  One sub-module, pp_row: combinational, WIDTH AND gates, row = x & {WIDTH{ybit}}.
//   Instantiated once and fed y_r[cnt]. The shift-add and the FSM live in pp_mult_seq_ctrl.
// TESTING
//  1. rst pulse, then x=15, y=15 with in_valid for 1 cycle -> in_ready=0 for 5 cycles; out_valid in cycle 4; p=225 (8'hE1).
//  2. x=0, y=9 -> out_valid after exactly 4 cycles with p=0. Repeat with x=9, y=0 -> p=0.
//  3. x=13, y=11, out_ready held low for 5 cycles -> out_valid and p=143 (8'h8F) stable throughout; IDLE in the cycle after out_ready=1.
//  4. Back-to-back: in_valid held high, operands (3,5) then (7,6), out_ready=1 -> p=15 then p=42; second accept occurs only after return to IDLE.
//  5. x=12, y=10 accepted, rst asserted asynchronously in ACCUM (row_idx=2) -> outputs reset immediately; no out_valid ever; next op 2*3 gives p=6.
//  6. During ACCUM, toggle in_valid and change x/y to 4'hF -> ignored; result equals the originally latched product. Also sweep all 256 pairs against x*y.

Source files
------------

// File: rtl/pp_mult_pkg.sv
// Shared definitions for the serial partial-product multiplier.
//   state_t     : controller FSM state encoding
//   PP_WIDTH    : default operand width
package pp_mult_pkg;

    localparam int PP_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/pp_row.sv
// One partial-product row: the multiplicand gated by a single multiplier bit.
//   x    : multiplicand (WIDTH)
//   ybit : selected multiplier bit
//   row  : x & {WIDTH{ybit}}
module pp_row #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] x,
    input  logic             ybit,
    output logic [WIDTH-1:0] row
);

    assign row = x & {WIDTH{ybit}};

endmodule

// File: rtl/pp_mult_seq_ctrl.sv
// Serial unsigned WIDTH x WIDTH multiplier: one partial-product row is
// shifted and added into a 2*WIDTH accumulator per cycle.
//   clk, rst             : clock, async active-high reset
//   in_valid/in_ready    : operand handshake (accept only in IDLE)
//   x, y                 : multiplicand, multiplier
//   out_valid/out_ready  : product handshake (valid only in DONE)
//   p                    : product, forced to 0 outside DONE
//   busy                 : high in ACCUM or DONE
//   row_idx              : row being accumulated, 0 outside ACCUM
module pp_mult_seq_ctrl
    import pp_mult_pkg::*;
#(
    parameter int WIDTH = PP_WIDTH,
    parameter int CNT_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy,
    output logic [CNT_W-1:0]     row_idx
);

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     x_q, x_d;
    logic [WIDTH-1:0]     y_q, y_d;

    logic [WIDTH-1:0]     row;
    logic [2*WIDTH-1:0]   row_sh;

    pp_row #(.WIDTH(WIDTH)) u_row (
        .x    (x_q),
        .ybit (y_q[cnt_q]),
        .row  (row)
    );

    // Zero-extend before shifting so the top bits of the row are kept.
    assign row_sh = {{WIDTH{1'b0}}, row} << cnt_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    x_d     = x;
                    y_d     = y;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                // Product < 2^(2*WIDTH), so the sum never carries out.
                acc_d = acc_q + row_sh;
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_ACCUM) || (state_q == ST_DONE);
    // Gate p so partial sums never reach the consumer.
    assign p         = (state_q == ST_DONE) ? acc_q : '0;
    assign row_idx   = (state_q == ST_ACCUM) ? cnt_q : '0;

endmodule
